mavg_filter: RTL and testbench

Parametrised, runtime-configurable moving-average filter for the digitised detector sample stream. It is the successor of the fixed 7-tap averager. It uses a power-of-two window selectable at run time, a running-sum accumulator (one add and one subtract per sample, no wide adder tree), valid-qualified input, and a window-filled flag. It sits between the ADC capture stage and the trigger/pulse-detection logic.

---
 rtl/mavg_pkg.sv | 21 ++
 rtl/mavg_ring_buf.sv | 28 ++
 rtl/mavg_filter.sv | 142 ++++++++++++++
 tb/tb_mavg_filter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
// Shared types and helpers for the moving-average filter.
// Holds the FILL/RUN state encoding, the accumulator width and window clamping.
package mavg_pkg;

    typedef logic [0:0] mavg_state_t;

    localparam mavg_state_t StFill = 1'b0;
    localparam mavg_state_t StRun  = 1'b1;

    // The accumulator holds at most 2^max_log2 full-scale samples.
    function automatic int unsigned sum_width(input int unsigned data_w,
                                              input int unsigned max_log2);
        return data_w + max_log2;
    endfunction

    function automatic int unsigned clamp_win(input int unsigned win,
                                              input int unsigned max_log2);
        return (win > max_log2) ? max_log2 : win;
    endfunction

endpackage

// File: rtl/mavg_ring_buf.sv
// Sample history for the moving-average filter: synchronous write, asynchronous read.
// The storage array has no reset; readers gate stale contents themselves.
module mavg_ring_buf #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read returns the pre-write contents when raddr_i == waddr_i.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mavg_filter.sv
// Runtime-configurable power-of-two moving-average filter using a running sum.
// Define MAVG_RESID_EN to add the signed out_resid (sample minus average) output.
module mavg_filter
    import mavg_pkg::*;
#(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned MAX_LOG2 = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [$clog2(MAX_LOG2+1)-1:0]    win_log2,
    input  logic                             clear,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_full
`ifdef MAVG_RESID_EN
    ,
    output logic signed [DATA_W:0]           out_resid
`endif
);

    localparam int unsigned WinW = $clog2(MAX_LOG2 + 1);
    localparam int unsigned SumW = sum_width(DATA_W, MAX_LOG2);
    localparam int unsigned PtrW = MAX_LOG2;
    localparam int unsigned CntW = MAX_LOG2 + 1;
    localparam logic [WinW-1:0] WinRst = WinW'(clamp_win(0, MAX_LOG2));

    mavg_state_t       state_q, state_d;
    logic [WinW-1:0]   win_q, win_d, win_clamped, win_eff;
    logic [SumW-1:0]   sum_q, sum_d, sum_base;
    logic [PtrW-1:0]   wp_q, wp_d, rd_addr;
    logic [CntW-1:0]   fill_cnt_q, fill_cnt_d, win_len_q, win_len_eff;
    logic [DATA_W-1:0] rd_data, old_sample, avg;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_full_q, out_full_d;
    logic              restart;

    assign win_clamped = WinW'(clamp_win(32'(win_log2), MAX_LOG2));
    assign restart     = clear | (win_clamped != win_q);
    assign win_eff     = restart ? win_clamped : win_q;
    assign win_len_q   = CntW'(1) << win_q;
    assign win_len_eff = CntW'(1) << win_eff;
    // When the window spans the whole buffer this wraps to wp itself, the slot about to be
    // overwritten.
    assign rd_addr     = wp_q - PtrW'(win_len_q);
    assign old_sample  = (!restart && state_q == StRun) ? rd_data : '0;
    assign sum_base    = restart ? '0 : sum_q;

    mavg_ring_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (PtrW)
    ) u_ring_buf (
        .clk     (clk),
        .we_i    (in_valid),
        .waddr_i (wp_q),
        .wdata_i (in_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_clamped;
        sum_d      = sum_q;
        wp_d       = wp_q;
        fill_cnt_d = fill_cnt_q;
        out_full_d = out_full_q;
        out_data_d = out_data_q;
        avg        = '0;

        if (restart) begin
            state_d    = StFill;
            sum_d      = '0;
            fill_cnt_d = '0;
            out_full_d = 1'b0;
        end

        if (in_valid) begin
            wp_d  = wp_q + PtrW'(1);
            sum_d = sum_base + SumW'(in_data) - SumW'(old_sample);
            if (restart || state_q == StFill) begin
                fill_cnt_d = (restart ? '0 : fill_cnt_q) + CntW'(1);
                if (fill_cnt_d == win_len_eff) begin
                    state_d    = StRun;
                    out_full_d = 1'b1;
                end
            end
            avg        = DATA_W'(sum_d >> win_eff);
            out_data_d = avg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            win_q       <= WinRst;
            sum_q       <= '0;
            wp_q        <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            wp_q        <= wp_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= in_valid;
            out_data_q  <= out_data_d;
            out_full_q  <= out_full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_full  = out_full_q;

`ifdef MAVG_RESID_EN
    logic signed [DATA_W:0] resid_q, resid_d;

    always_comb begin
        resid_d = resid_q;
        if (in_valid) begin
            resid_d = $signed({1'b0, in_data}) - $signed({1'b0, avg});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resid_q <= '0;
        end else begin
            resid_q <= resid_d;
        end
    end

    assign out_resid = resid_q;
`endif

endmodule

// File: tb/tb_mavg_filter.sv
// Self-checking bench for mavg_filter: directed vector table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_mavg_filter;

    localparam int unsigned DATA_W   = 14;
    localparam int unsigned MAX_LOG2 = 4;
    localparam int          FullScale = 16383;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [2:0]        win_log2 = '0;
    logic              clear = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_full;
`ifdef MAVG_RESID_EN
    logic signed [DATA_W:0] out_resid;
`endif

    mavg_filter #(
        .DATA_W   (DATA_W),
        .MAX_LOG2 (MAX_LOG2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .win_log2  (win_log2),
        .clear     (clear),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_full  (out_full)
`ifdef MAVG_RESID_EN
        ,
        .out_resid (out_resid)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the samples accepted since the last restart, newest last.
    int unsigned m_win;
    int          m_hist[$];
    int          m_data;
    bit          m_full;
    bit          m_valid;
    int          m_resid;

    typedef struct {
        bit          v;
        int          d;
        int unsigned w;
        bit          c;
        bit          exp_v;
        int          exp_d;
        bit          exp_full;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_win   = 0;
        m_hist.delete();
        m_data  = 0;
        m_full  = 1'b0;
        m_valid = 1'b0;
        m_resid = 0;
    endfunction

    function automatic void model_step(input bit v, input int d, input int unsigned w,
                                       input bit c);
        int unsigned wc;
        int n;
        int s;
        wc = (w > MAX_LOG2) ? MAX_LOG2 : w;
        m_valid = v;
        if (c || wc != m_win) begin
            m_win = wc;
            m_hist.delete();
            m_full = 1'b0;
        end
        if (v) begin
            m_hist.push_back(d);
            if (m_hist.size() > (1 << MAX_LOG2)) void'(m_hist.pop_front());
            n = 1 << m_win;
            s = 0;
            for (int i = 0; i < n && i < m_hist.size(); i++) s += m_hist[m_hist.size() - 1 - i];
            m_data  = s / n;
            m_full  = (m_hist.size() >= n);
            m_resid = d - m_data;
        end
    endfunction

    task automatic step(input bit v, input int d, input int unsigned w, input bit c);
        in_valid = v;
        in_data  = DATA_W'(d);
        win_log2 = 3'(w);
        clear    = c;
        @(posedge clk);
        #1;
        model_step(v, d, w, c);
        check("model_valid", out_valid, m_valid);
        check("model_data", out_data, m_data);
        check("model_full", out_full, m_full);
`ifdef MAVG_RESID_EN
        if (v) check("model_resid", out_resid, m_resid);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_full"}, out_full, 0);
`ifdef MAVG_RESID_EN
        check({tag, "_resid"}, out_resid, 0);
`endif
    endtask

    function automatic void add(input bit v, input int d, input int unsigned w, input bit c,
                                input bit ev, input int ed, input bit ef);
        vec_t e;
        e.v = v; e.d = d; e.w = w; e.c = c;
        e.exp_v = ev; e.exp_d = ed; e.exp_full = ef;
        tbl.push_back(e);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fill_exp[5];
        int unsigned cur_w;
        fill_exp = '{25, 75, 150, 250, 350};

        // Power-on reset
        #2 rst_n = 1'b0;
        #2 check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Directed vectors: reset sample, fill, clear, window change, clamping
        add(1, 40, 2, 0, 1, 10, 0);
        add(1, 100, 2, 1, 1, 25, 0);
        add(1, 200, 2, 0, 1, 75, 0);
        add(1, 300, 2, 0, 1, 150, 0);
        add(1, 400, 2, 0, 1, 250, 1);
        add(1, 500, 2, 0, 1, 350, 1);
        add(1, 8, 2, 1, 1, 2, 0);
        add(1, 8, 2, 0, 1, 4, 0);
        add(1, 8, 2, 0, 1, 6, 0);
        add(1, 8, 2, 0, 1, 8, 1);
        add(1, 10, 1, 0, 1, 5, 0);
        add(1, 20, 1, 0, 1, 15, 1);
        add(1, 30, 1, 0, 1, 25, 1);
        add(1, 16, 7, 0, 1, 1, 0);
        for (int k = 2; k <= 16; k++) add(1, 16, 7, 0, 1, k, k == 16);
        add(0, 0, 7, 1, 0, 16, 0);
        add(1, 48, 7, 0, 1, 3, 0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].w, tbl[i].c);
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_v);
            check($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_d);
            check($sformatf("tbl%0d_full", i), out_full, tbl[i].exp_full);
        end

        // Gaps between samples must not change the result sequence
        step(0, 0, 2, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 100 * (i + 1), 2, 0);
            check($sformatf("gap_data%0d", i), out_data, fill_exp[i]);
            check($sformatf("gap_full%0d", i), out_full, i >= 3);
            if (i < 4) begin
                for (int g = 0; g < 3; g++) begin
                    step(0, 0, 2, 0);
                    check("gap_idle_valid", out_valid, 0);
                    check("gap_hold_data", out_data, fill_exp[i]);
                end
            end
        end

        // Full-scale input across buffer wrap-around
        step(0, 0, 4, 1);
        for (int i = 0; i < 40; i++) begin
            step(1, FullScale, 4, 0);
            if (i >= 15) begin
                check("fs_data", out_data, FullScale);
                check("fs_full", out_full, 1);
`ifdef MAVG_RESID_EN
                check("fs_resid", out_resid, 0);
`endif
            end
        end

        // Asynchronous reset mid-stream, well away from a clock edge
        for (int i = 0; i < 3; i++) step(1, 1000 + i, 2, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 40, 2, 0);
        check("rst_first_data", out_data, 10);
        check("rst_first_full", out_full, 0);

        // Randomized traffic against the reference model
        cur_w = 2;
        for (int i = 0; i < 500; i++) begin
            bit v;
            bit c;
            int d;
            if ($urandom_range(39, 0) == 0) cur_w = $urandom_range(7, 0);
            c = ($urandom_range(49, 0) == 0);
            v = ($urandom_range(3, 0) != 0);
            d = ($urandom_range(7, 0) == 0) ? FullScale : int'($urandom_range(FullScale, 0));
            step(v, d, cur_w, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
